// File: rtl/sbox_layer_seq.sv
// Nibble-serial substitution layer: one shared 4-bit sbox walks LSB-first across
// a 4*NIB-bit block, with valid/ready handshakes on both sides.
module sbox_layer_seq #(
    parameter int NIB = 16,
    parameter int CW  = $clog2(NIB)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4*NIB-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4*NIB-1:0] out_data,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [4*NIB-1:0] data_q;
    logic             load;
    logic             last;
    logic [3:0]       nib_cur;
    logic [3:0]       nib_sub;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] r;
        case (x)
            4'h0: r = 4'hC;
            4'h1: r = 4'h5;
            4'h2: r = 4'h6;
            4'h3: r = 4'hB;
            4'h4: r = 4'h9;
            4'h5: r = 4'h0;
            4'h6: r = 4'hA;
            4'h7: r = 4'hD;
            4'h8: r = 4'h3;
            4'h9: r = 4'hE;
            4'hA: r = 4'hF;
            4'hB: r = 4'h8;
            4'hC: r = 4'h4;
            4'hD: r = 4'h7;
            4'hE: r = 4'h1;
            default: r = 4'h2;
        endcase
        return r;
    endfunction

    assign load     = in_valid & in_ready;
    assign last     = (cnt == CW'(NIB - 1));
    assign nib_cur  = data_q[4*cnt +: 4];
    assign nib_sub  = sbox(nib_cur);
    assign out_data = data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid) state_nxt = SUB;
            SUB:  if (last) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = in_valid ? SUB : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // in_ready depends on out_ready only, never on in_valid
    always_comb begin
        in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
        out_valid = (state == DONE);
        busy      = (state == SUB);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            data_q <= '0;
        end else if (load) begin
            cnt    <= '0;
            data_q <= in_data;
        end else if (state == SUB) begin
            data_q[4*cnt +: 4] <= nib_sub;
            cnt                <= last ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_sbox_layer_seq.sv
// Self-checking bench for sbox_layer_seq: directed scenarios plus a randomized
// scoreboard run against a nibble-wise reference model.
module tb_sbox_layer_seq;

    localparam int NIB = 16;
    localparam int W   = 4 * NIB;
    // sbox table, entry x at bits [4x+3:4x]
    localparam logic [63:0] SB_TAB = 64'h21748FE3DA09B65C;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         busy;

    int           n_tests = 0;
    int           n_fail  = 0;
    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    sbox_layer_seq #(.NIB(NIB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    function automatic logic [W-1:0] ref_sub(input logic [W-1:0] d);
        logic [W-1:0] r;
        logic [3:0]   x;
        r = '0;
        for (int i = 0; i < NIB; i++) begin
            x = d[4*i +: 4];
            r[4*i +: 4] = SB_TAB[4*x +: 4];
        end
        return r;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        @(negedge clk);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy); end
        n_tests++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data got %h want 0", out_data); end
        rst_n = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; in_data = 64'h0123456789ABCDEF;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midrun_busy got %0b want 1", busy); end
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL async_rst_out_valid got %0b want 0", out_valid); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL async_rst_in_ready got %0b want 1", in_ready); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL async_rst_busy got %0b want 0", busy); end
        n_tests++; if (out_data !== '0) begin n_fail++; $display("FAIL async_rst_out_data got %h want 0", out_data); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++; if (busy !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL post_rst_idle got busy=%0b out_valid=%0b want 0/0", busy, out_valid); end
    endtask

    task automatic test_zero();
        int cycles;
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = '0;
        #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL zero_in_ready got %0b want 1", in_ready); end
        exp_q.push_back(64'hCCCCCCCCCCCCCCCC);
        @(negedge clk);
        in_valid = 1'b0;
        cycles = 0;
        while (!out_valid && cycles < 40) begin @(negedge clk); cycles++; end
        n_tests++; if (cycles !== 16) begin n_fail++; $display("FAIL zero_latency got %0d want 16", cycles); end
        n_tests++; if (out_data !== exp_q.pop_front()) begin n_fail++; $display("FAIL zero_out_data got %h want cccccccccccccccc", out_data); end
        @(negedge clk);
        n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL zero_drain got out_valid=%0b in_ready=%0b want 0/1", out_valid, in_ready); end
    endtask

    task automatic test_pattern();
        int cycles;
        int busy_cnt;
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 64'h0123456789ABCDEF;
        exp_q.push_back(64'hC56B90AD3EF84712);
        @(negedge clk);
        in_valid = 1'b0;
        cycles = 0; busy_cnt = 0;
        while (!out_valid && cycles < 40) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            cycles++;
        end
        n_tests++; if (cycles !== 16) begin n_fail++; $display("FAIL pattern_latency got %0d want 16", cycles); end
        n_tests++; if (busy_cnt !== 16) begin n_fail++; $display("FAIL pattern_busy_cycles got %0d want 16", busy_cnt); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL pattern_busy_in_done got %0b want 0", busy); end
        n_tests++; if (out_data !== exp_q.pop_front()) begin n_fail++; $display("FAIL pattern_out_data got %h want c56b90ad3ef84712", out_data); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int cycles;
        logic [W-1:0] e;
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 64'h0011223344556677;
        exp_q.push_back(ref_sub(64'h0011223344556677));
        e = exp_q[0];
        @(negedge clk);
        in_valid = 1'b0;
        cycles = 0;
        while (!out_valid && cycles < 40) begin @(negedge clk); cycles++; end
        n_tests++; if (cycles !== 16) begin n_fail++; $display("FAIL bp_latency got %0d want 16", cycles); end
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            in_data  = {$urandom, $urandom};
            #1;
            n_tests++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold_ctrl cycle %0d got out_valid=%0b in_ready=%0b want 1/0", i, out_valid, in_ready); end
            n_tests++; if (out_data !== e) begin n_fail++; $display("FAIL bp_hold_data cycle %0d got %h want %h", i, out_data, e); end
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready got %0b want 1", in_ready); end
        n_tests++; if (out_data !== exp_q.pop_front()) begin n_fail++; $display("FAIL bp_release_data got %h want %h", out_data, e); end
        @(negedge clk);
        n_tests++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL bp_no_extra_block got out_valid=%0b busy=%0b want 0/0", out_valid, busy); end
    endtask

    task automatic test_back_to_back();
        int cycles;
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 64'h0123456789ABCDEF;
        exp_q.push_back(64'hC56B90AD3EF84712);
        @(negedge clk);
        in_valid = 1'b0;
        cycles = 0;
        while (!out_valid && cycles < 40) begin @(negedge clk); cycles++; end
        in_valid = 1'b1; in_data = 64'hFFFFFFFFFFFFFFFF;
        #1;
        n_tests++; if (in_ready !== 1'b1 || out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_dual_handshake got in_ready=%0b out_valid=%0b want 1/1", in_ready, out_valid); end
        n_tests++; if (out_data !== exp_q.pop_front()) begin n_fail++; $display("FAIL b2b_first_data got %h want c56b90ad3ef84712", out_data); end
        exp_q.push_back(64'h2222222222222222);
        @(negedge clk);
        in_valid = 1'b0;
        n_tests++; if (out_valid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL b2b_restart got out_valid=%0b busy=%0b want 0/1", out_valid, busy); end
        cycles = 0;
        while (!out_valid && cycles < 40) begin @(negedge clk); cycles++; end
        n_tests++; if (cycles !== 16) begin n_fail++; $display("FAIL b2b_latency got %0d want 16", cycles); end
        n_tests++; if (out_data !== exp_q.pop_front()) begin n_fail++; $display("FAIL b2b_second_data got %h want 2222222222222222", out_data); end
        @(negedge clk);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got %0b want 0", out_valid); end
    endtask

    task automatic test_random();
        int           sent;
        int           recv;
        logic         acc;
        logic         hold_in;
        logic         stall_prev;
        logic [W-1:0] stall_data;
        logic [W-1:0] e;
        sent = 0; recv = 0; hold_in = 1'b0; stall_prev = 1'b0; stall_data = '0;
        in_valid = 1'b0; out_ready = 1'b0;
        exp_q.delete();
        for (int cyc = 0; cyc < 60000 && recv < 1000; cyc++) begin
            @(negedge clk);
            if (stall_prev) begin
                n_tests++;
                if (out_valid !== 1'b1 || out_data !== stall_data) begin
                    n_fail++; $display("FAIL rand_stall_stable got out_valid=%0b data=%h want 1/%h", out_valid, out_data, stall_data);
                end
            end
            if (!hold_in) begin
                in_valid = (sent < 1000) && ($urandom_range(0, 3) != 0);
                in_data  = {$urandom, $urandom};
            end
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            acc = in_valid && in_ready;
            if (out_valid && out_ready) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL rand_unexpected_output got %h want none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e) begin n_fail++; $display("FAIL rand_data block %0d got %h want %h", recv, out_data, e); end
                end
                recv++;
            end
            if (acc) begin exp_q.push_back(ref_sub(in_data)); sent++; end
            hold_in    = in_valid && !acc;
            stall_prev = out_valid && !out_ready;
            stall_data = out_data;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_tests++; if (recv !== 1000 || sent !== 1000) begin n_fail++; $display("FAIL rand_block_count got sent=%0d recv=%0d want 1000/1000", sent, recv); end
        n_tests++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL rand_leftover got %0d want 0", exp_q.size()); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_zero();
        test_pattern();
        test_backpressure();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
